// File: rtl/sram_kn_row_streamer.sv
// ---------------------------------------------------------------------------
// sram_kn_row_streamer
//
// Read-side sequencer for the k-major KxN word memory. A command names a row
// range [k_base, k_base+k_len). For every row the block reads n = 0..N-1 on
// the memory k/n port, buffers the returned words in a small FIFO, and
// presents them as a valid/ready stream tagged with k/n and row/frame-last
// flags.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             command strobe (only looked at in IDLE)
//   k_base, k_len     first row and number of rows of the command
//   busy              high while a command is being processed
//   done              one-cycle pulse after the final beat is accepted
//   cmd_err           one-cycle pulse when a command is rejected
//   m_en, m_re        memory enable / read strobe (combinational)
//   m_we, m_wdata,
//   m_wmask           write side of the memory port, tied 0
//   m_k, m_n          memory row / column address
//   m_rdata, m_rvalid read data return from the memory (in order, latency>=1)
//   o_valid, o_ready  output stream handshake
//   o_data, o_k, o_n  stream word and its row / column
//   o_last_row        word is the last of its row (n == N-1)
//   o_last            word is the last of the command
//   dbg_state         current FSM state, for observation only
//
// Handshake: a beat transfers on every rising clock edge where
// o_valid && o_ready are both high. Once o_valid is raised, o_data, o_k,
// o_n, o_last_row and o_last hold their values until that transfer happens;
// o_valid never drops without a transfer.
// ---------------------------------------------------------------------------
module sram_kn_row_streamer #(
  parameter int KMAX       = 1024,
  parameter int N          = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int K_W        = (KMAX <= 1) ? 1 : $clog2(KMAX),
  parameter int N_W        = (N <= 1) ? 1 : $clog2(N),
  parameter int LEN_W      = K_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [K_W-1:0]        k_base,
  input  logic [LEN_W-1:0]      k_len,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err,
  output logic                  m_en,
  output logic                  m_re,
  output logic                  m_we,
  output logic [K_W-1:0]        m_k,
  output logic [N_W-1:0]        m_n,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wmask,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_rvalid,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_W-1:0]     o_data,
  output logic [K_W-1:0]        o_k,
  output logic [N_W-1:0]        o_n,
  output logic                  o_last_row,
  output logic                  o_last,
  output logic [1:0]            dbg_state
);

  // FIFO pointer width and occupancy-counter width (counts 0..FIFO_DEPTH).
  localparam int AW = (FIFO_DEPTH <= 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW:0]      DEPTH_L = (CW+1)'(FIFO_DEPTH);
  localparam logic [LEN_W:0]   KMAX_L  = (LEN_W+1)'(KMAX);
  localparam logic [N_W-1:0]   N_LAST  = N_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Issue pointer (next read to send) and output pointer (row/col of the
  // FIFO head). They move independently: issue runs ahead by at most
  // FIFO_DEPTH words.
  logic [K_W-1:0] ik_q, ik_d;
  logic [N_W-1:0] in_q, in_d;
  logic [K_W-1:0] ok_q, ok_d;
  logic [N_W-1:0] on_q, on_d;
  logic [K_W-1:0] last_k_q, last_k_d;

  logic [CW-1:0]  outstanding_q, outstanding_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           cmd_err_q, cmd_err_d;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  // Command validation. The end row is formed one bit wider than k_len so
  // that k_base + k_len can never wrap and slip under KMAX.
  logic [LEN_W:0]  cmd_end;
  logic [K_W-1:0]  cmd_last_k;
  logic            cmd_ok;
  logic            accept;

  assign cmd_end    = (LEN_W+1)'(k_base) + (LEN_W+1)'(k_len);
  assign cmd_ok     = (k_len != '0) && (cmd_end <= KMAX_L);
  // Only meaningful when cmd_ok; then the true last row fits in K_W bits,
  // so modular arithmetic on K_W bits gives the exact value.
  assign cmd_last_k = k_base + K_W'(k_len - LEN_W'(1));
  assign accept     = (state_q == ST_IDLE) && start && cmd_ok;

  // Credit: every read in flight already owns a FIFO slot, so counting
  // outstanding reads together with buffered words guarantees the FIFO can
  // absorb every return regardless of memory latency.
  logic [CW:0] used;
  logic        issue;
  logic        push;
  logic        pop;
  logic        issue_last;

  assign used       = {1'b0, outstanding_q} + {1'b0, count_q};
  assign issue      = (state_q == ST_ISSUE) && (used < DEPTH_L);
  assign issue_last = issue && (ik_q == last_k_q) && (in_q == N_LAST);
  // A return with nothing outstanding cannot belong to this command
  // (e.g. stale data around a reset), so it is dropped.
  assign push       = m_rvalid && (outstanding_q != '0);
  assign pop        = o_valid && o_ready;

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign o_valid    = (count_q != '0);
  assign o_data     = o_valid ? fifo_mem[rd_ptr_q] : '0;
  assign o_k        = ok_q;
  assign o_n        = on_q;
  assign o_last_row = (on_q == N_LAST);
  assign o_last     = o_last_row && (ok_q == last_k_q);

  assign m_en       = issue;
  assign m_re       = issue;
  assign m_we       = 1'b0;
  assign m_k        = issue ? ik_q : '0;
  assign m_n        = issue ? in_q : '0;
  assign m_wdata    = '0;
  assign m_wmask    = '0;

  assign busy       = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign cmd_err    = cmd_err_q;
  assign dbg_state  = state_q;

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: if (issue_last) state_d = ST_DRAIN;
      // The final beat cannot leave the FIFO before its read has issued,
      // so the o_last transfer is only ever seen in DRAIN.
      ST_DRAIN: if (pop && o_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  always_comb begin
    ik_d          = ik_q;
    in_d          = in_q;
    ok_d          = ok_q;
    on_d          = on_q;
    last_k_d      = last_k_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cmd_err_d     = (state_q == ST_IDLE) && start && !cmd_ok;

    if (accept) begin
      ik_d     = k_base;
      in_d     = '0;
      ok_d     = k_base;
      on_d     = '0;
      last_k_d = cmd_last_k;
    end

    if (issue) begin
      if (in_q == N_LAST) begin
        in_d = '0;
        ik_d = ik_q + K_W'(1);
      end else begin
        in_d = in_q + N_W'(1);
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (on_q == N_LAST) begin
        on_d = '0;
        ok_d = ok_q + K_W'(1);
      end else begin
        on_d = on_q + N_W'(1);
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    unique case ({issue, push})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ik_q          <= '0;
      in_q          <= '0;
      ok_q          <= '0;
      on_q          <= '0;
      last_k_q      <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ik_q          <= ik_d;
      in_q          <= in_d;
      ok_q          <= ok_d;
      on_q          <= on_d;
      last_k_q      <= last_k_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  // FIFO storage carries no reset: an entry is only read after it has been
  // written, and o_data is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= m_rdata;
    end
  end

endmodule

// File: tb/tb_sram_kn_row_streamer.sv
`timescale 1ns/1ps
module tb_sram_kn_row_streamer;

  localparam int KMAX       = 1024;
  localparam int N          = 8;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int K_W        = 10;
  localparam int N_W        = 3;
  localparam int LEN_W      = 11;
  localparam int BW         = DATA_W + K_W + N_W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                start;
  logic [K_W-1:0]      k_base;
  logic [LEN_W-1:0]    k_len;
  logic                busy, done, cmd_err;
  logic                m_en, m_re, m_we;
  logic [K_W-1:0]      m_k;
  logic [N_W-1:0]      m_n;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wmask;
  logic [DATA_W-1:0]   m_rdata;
  logic                m_rvalid;
  logic                o_valid, o_ready;
  logic [DATA_W-1:0]   o_data;
  logic [K_W-1:0]      o_k;
  logic [N_W-1:0]      o_n;
  logic                o_last_row, o_last;
  logic [1:0]          dbg_state;

  sram_kn_row_streamer #(
    .KMAX(KMAX), .N(N), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_base(k_base), .k_len(k_len),
    .busy(busy), .done(done), .cmd_err(cmd_err),
    .m_en(m_en), .m_re(m_re), .m_we(m_we), .m_k(m_k), .m_n(m_n),
    .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_k(o_k), .o_n(o_n),
    .o_last_row(o_last_row), .o_last(o_last), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;

  logic [BW-1:0]        exp_q[$];    // expected stream beats
  logic [K_W+N_W-1:0]   iss_q[$];    // expected read addresses in order
  logic [DATA_W-1:0]    pend_data[$];
  int                   pend_due[$];
  int                   last_due = 0;

  logic [DATA_W-1:0]    acc_data[$]; // accepted beats of the current command
  int                   beat_cyc[$];
  int                   nrow = 0, nlast = 0;
  int                   done_cnt = 0, err_cnt = 0;
  int                   last_cyc = -10;
  int                   cyc = 0;
  int                   reqs = 0, pops = 0;

  int lat_min = 1, lat_max = 1, ready_pct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory preload image: mem[k*8+n] = 0x100*k + n
  function automatic logic [DATA_W-1:0] mem_word(input int k, input int n);
    return DATA_W'(k * 256 + n);
  endfunction

  // ---------------- memory model + sink + compare process ----------------
  initial begin
    int due;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    o_ready  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_rvalid = 1'b0;
        m_rdata  = '0;
        pend_data.delete();
        pend_due.delete();
      end else begin
        // reads issued minus beats popped, all already captured by the DUT
        check("credit_used_le_depth", (reqs - pops) <= FIFO_DEPTH, 1);

        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
          m_rvalid = 1'b1;
          m_rdata  = pend_data.pop_front();
          void'(pend_due.pop_front());
        end else begin
          m_rvalid = 1'b0;
          m_rdata  = '0;
        end

        if (m_en || m_re) begin
          check("mem_strobes", {m_en, m_re, m_we}, 3'b110);
          check("read_expected", iss_q.size() != 0, 1);
          if (iss_q.size() != 0) check("read_addr", {m_k, m_n}, iss_q.pop_front());
          reqs++;
          due = cyc + $urandom_range(lat_min, lat_max);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend_data.push_back(mem_word(int'(m_k), int'(m_n)));
          pend_due.push_back(due);
        end

        o_ready = ($urandom_range(0, 99) < ready_pct);
        #2;
        if (o_valid) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            check("beat", {o_data, o_k, o_n, o_last_row, o_last}, exp_q[0]);
            if (o_ready) begin
              void'(exp_q.pop_front());
              pops++;
              acc_data.push_back(o_data);
              beat_cyc.push_back(cyc);
              if (o_last_row) nrow++;
              if (o_last) begin
                nlast++;
                last_cyc = cyc;
              end
            end
          end
        end
        if (done) begin
          done_cnt++;
          check("done_timing", cyc, last_cyc + 1);
        end
        if (cmd_err) err_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input int base, input int len);
    @(negedge clk);
    start  = 1'b1;
    k_base = K_W'(base);
    k_len  = LEN_W'(len);
    if (len != 0 && base + len <= KMAX) begin
      acc_data.delete();
      beat_cyc.delete();
      nrow  = 0;
      nlast = 0;
      for (int k = base; k < base + len; k++) begin
        for (int n = 0; n < N; n++) begin
          iss_q.push_back({K_W'(k), N_W'(n)});
          exp_q.push_back({mem_word(k, n), K_W'(k), N_W'(n), n == N - 1,
                           (n == N - 1) && (k == base + len - 1)});
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int i;
    d0 = done_cnt;
    i  = 0;
    while (done_cnt == d0 && i < budget) begin
      @(negedge clk);
      #3;
      i++;
    end
    check("done_seen", done_cnt != d0, 1);
    @(negedge clk);
    #3;
    check("done_one_cycle", done, 0);
    check("busy_low_after_done", busy, 0);
    check("exp_drained", exp_q.size(), 0);
    check("iss_drained", iss_q.size(), 0);
  endtask

  task automatic reject_cmd(input int base, input int len);
    int e0;
    e0 = err_cnt;
    send_cmd(base, len);
    #1;
    check("cmd_err_pulse", cmd_err, 1);
    check("busy_after_reject", busy, 0);
    repeat (4) @(negedge clk);
    #3;
    check("cmd_err_count", err_cnt, e0 + 1);
    check("idle_after_reject", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {busy, done, cmd_err, m_en, m_re, m_we, m_wmask,
                          o_valid, o_last_row, o_last}, 0);
    check({tag, "_addr"}, {m_k, m_n, o_k, o_n}, 0);
    check({tag, "_data"}, {o_data, m_wdata}, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int d0;
    int e0;
    int i;
    start  = 1'b0;
    k_base = '0;
    k_len  = '0;

    #1 rst = 1'b1;
    #1 check_all_zero("reset_state");
    @(negedge clk);
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single row, 1-cycle latency, always ready
    lat_min = 1; lat_max = 1; ready_pct = 100;
    send_cmd(3, 1);
    #1 check("busy_after_start", busy, 1);
    wait_done(200);
    check("t1_beats", acc_data.size(), 8);
    if (acc_data.size() == 8) begin
      check("t1_first", acc_data[0], 32'h300);
      check("t1_last", acc_data[7], 32'h307);
      check("t1_back_to_back", beat_cyc[7] - beat_cyc[0], 7);
    end
    check("t1_last_row_cnt", nrow, 1);
    check("t1_last_cnt", nlast, 1);

    // 2: multi-row, issued right after done (back-to-back)
    send_cmd(5, 3);
    wait_done(300);
    check("t2_beats", acc_data.size(), 24);
    if (acc_data.size() == 24) begin
      check("t2_row6_first", acc_data[8], 32'h600);
      check("t2_last", acc_data[23], 32'h707);
    end
    check("t2_last_row_cnt", nrow, 3);
    check("t2_last_cnt", nlast, 1);

    // 3: backpressure with variable memory latency
    lat_min = 1; lat_max = 3; ready_pct = 30;
    send_cmd(2, 4);
    wait_done(3000);
    check("t3_beats", acc_data.size(), 32);
    if (acc_data.size() == 32) check("t3_last", acc_data[31], 32'h507);
    check("t3_last_cnt", nlast, 1);

    // 4: bounds
    lat_min = 1; lat_max = 2; ready_pct = 100;
    send_cmd(1022, 2);
    wait_done(300);
    check("t4_beats", acc_data.size(), 16);
    if (acc_data.size() == 16) begin
      check("t4_first", acc_data[0], 32'h3FE00);
      check("t4_last", acc_data[15], 32'h3FF07);
    end
    reject_cmd(1022, 3);
    reject_cmd(0, 0);

    // 5: start while busy is ignored
    lat_min = 1; lat_max = 3; ready_pct = 60;
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(10, 2);
    repeat (3) @(negedge clk);
    start = 1'b1; k_base = K_W'(0); k_len = LEN_W'(1);
    @(negedge clk);
    k_len = LEN_W'(0);
    @(negedge clk);
    start = 1'b0;
    wait_done(1000);
    repeat (20) @(negedge clk);
    #3;
    check("t5_done_once", done_cnt, d0 + 1);
    check("t5_no_err", err_cnt, e0);
    check("t5_beats", acc_data.size(), 16);
    if (acc_data.size() == 16) check("t5_first", acc_data[0], 32'hA00);

    // 6: async reset on beat 5 of a 3-row command
    lat_min = 1; lat_max = 1; ready_pct = 100;
    send_cmd(20, 3);
    i = 0;
    while (acc_data.size() < 4 && i < 200) begin
      @(negedge clk);
      #3;
      i++;
    end
    check("t6_reached_beat5", acc_data.size() >= 4, 1);
    rst = 1'b1;
    exp_q.delete();
    iss_q.delete();
    pend_data.delete();
    pend_due.delete();
    last_due = 0;
    reqs = 0;
    pops = 0;
    #1 check_all_zero("t6_reset");
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    send_cmd(0, 1);
    wait_done(200);
    check("t6_beats", acc_data.size(), 8);
    if (acc_data.size() == 8) begin
      check("t6_first", acc_data[0], 32'h0);
      check("t6_last", acc_data[7], 32'h7);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
